sdram_wb_arb: RTL and testbench



---
 rtl/sdram_arb_rr_pick.sv | 27 ++
 rtl/sdram_wb_arb.sv | 179 +++++++++++++++++
 tb/tb_sdram_wb_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_rr_pick.sv
// Round-robin winner selection: first requester found searching upward from
// last+1 (mod NM). Purely combinational.
module sdram_arb_rr_pick #(
   parameter int unsigned NM = 3,
   parameter int unsigned IW = 2
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] win,
   output logic          vld
);

   // Walk from farthest to nearest so the nearest requester after 'last' wins.
   always_comb begin
      win = '0;
      vld = 1'b0;
      for (int unsigned i = NM; i >= 1; i--) begin
         for (int unsigned k = 0; k < NM; k++) begin
            if (req[k] && (k == ((32'(last) + i) % NM))) begin
               win = IW'(k);
               vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_wb_arb.sv
// Wishbone classic arbiter in front of the SDRAM slave port: round-robin
// grants held for a whole cyc burst, plus a watchdog that errors hung cycles.
`ifndef SDRAM_ADR_WIDTH
`define SDRAM_ADR_WIDTH 24
`endif
`ifndef WB_DATA_WIDTH
`define WB_DATA_WIDTH 32
`endif
`ifndef WB_SEL_WIDTH
`define WB_SEL_WIDTH 4
`endif
`ifndef SDRAM_ARB_NM
`define SDRAM_ARB_NM 3
`endif
`ifndef SDRAM_ARB_TMO
`define SDRAM_ARB_TMO 255
`endif

module sdram_wb_arb #(
   parameter int unsigned NM  = `SDRAM_ARB_NM,
   parameter int unsigned AW  = `SDRAM_ADR_WIDTH,
   parameter int unsigned DW  = `WB_DATA_WIDTH,
   parameter int unsigned SW  = `WB_SEL_WIDTH,
   parameter int unsigned TMO = `SDRAM_ARB_TMO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NM*AW-1:0] m_adr_i,
   input  logic [NM*DW-1:0] m_dat_i,
   input  logic [NM*SW-1:0] m_sel_i,
   input  logic [NM-1:0]    m_we_i,
   input  logic [NM-1:0]    m_cyc_i,
   input  logic [NM-1:0]    m_stb_i,
   output logic [DW-1:0]    m_dat_o,
   output logic [NM-1:0]    m_ack_o,
   output logic [NM-1:0]    m_err_o,
   output logic [NM-1:0]    m_rty_o,
   output logic [AW-1:0]    s_adr_o,
   output logic [DW-1:0]    s_dat_o,
   output logic [SW-1:0]    s_sel_o,
   output logic             s_we_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   input  logic [DW-1:0]    s_dat_i,
   input  logic             s_ack_i,
   input  logic             s_err_i,
   input  logic             s_rty_i,
   output logic [NM-1:0]    gnt_o,
   output logic             tmo_o,
   output logic [1:0]       tmo_mst_o,
   input  logic             tmo_clr_i
);

   localparam int unsigned IW = 2;
   localparam int unsigned CW = 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_d;
   logic [IW-1:0] g, g_d;
   logic [IW-1:0] last, last_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          tmo_d;
   logic [1:0]    tmo_mst_d;

   logic [NM-1:0] req;
   logic [IW-1:0] win;
   logic          win_vld;
   logic          busy;
   logic          fire;
   logic          cyc_g;
   logic          s_term;

   assign req    = m_cyc_i & m_stb_i;
   assign busy   = (state == BUSY);
   assign fire   = busy && (cnt == CW'(TMO));
   assign s_term = s_ack_i | s_err_i | s_rty_i;
   assign m_dat_o = s_dat_i;

   sdram_arb_rr_pick #(
      .NM (NM),
      .IW (IW)
   ) u_rr_pick (
      .req  (req),
      .last (last),
      .win  (win),
      .vld  (win_vld)
   );

   // Slave-side mux of the granted master and per-master termination routing.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      cyc_g   = 1'b0;
      gnt_o   = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         if (busy && (g == IW'(k))) begin
            s_adr_o    = m_adr_i[k*AW +: AW];
            s_dat_o    = m_dat_i[k*DW +: DW];
            s_sel_o    = m_sel_i[k*SW +: SW];
            s_we_o     = m_we_i[k];
            s_cyc_o    = m_cyc_i[k] & ~fire;
            s_stb_o    = m_stb_i[k] & ~fire;
            cyc_g      = m_cyc_i[k];
            gnt_o[k]   = 1'b1;
            m_ack_o[k] = s_ack_i & ~fire;
            m_err_o[k] = s_err_i | fire;
            m_rty_o[k] = s_rty_i & ~fire;
         end
      end
   end

   // Next-state: grant/handoff, watchdog counter and sticky timeout flag.
   always_comb begin
      state_d   = state;
      g_d       = g;
      last_d    = last;
      cnt_d     = cnt;
      tmo_d     = tmo_o;
      tmo_mst_d = tmo_mst_o;

      if (!s_stb_o || s_term) cnt_d = '0;
      else                    cnt_d = cnt + CW'(1);

      if (tmo_clr_i) tmo_d = 1'b0;

      case (state)
         IDLE: begin
            if (win_vld) begin
               state_d = BUSY;
               g_d     = win;
               last_d  = win;
            end
         end
         BUSY: begin
            if (fire) begin
               state_d   = IDLE;
               last_d    = g;
               tmo_d     = 1'b1;
               tmo_mst_d = g;
            end else if (!cyc_g) begin
               if (win_vld) begin
                  g_d    = win;
                  last_d = win;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         g         <= '0;
         last      <= IW'(NM - 1);
         cnt       <= '0;
         tmo_o     <= 1'b0;
         tmo_mst_o <= '0;
      end else begin
         state     <= state_d;
         g         <= g_d;
         last      <= last_d;
         cnt       <= cnt_d;
         tmo_o     <= tmo_d;
         tmo_mst_o <= tmo_mst_d;
      end
   end

endmodule

// File: tb/tb_sdram_wb_arb.sv
// Directed self-checking bench for sdram_wb_arb (3 masters, watchdog limit 8).
`timescale 1ns/1ps
module tb_sdram_wb_arb;

   localparam int unsigned NM  = 3;
   localparam int unsigned AW  = 24;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int unsigned TMO = 8;

   logic             clk;
   logic             rst;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [NM-1:0]    m_we_i;
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic             s_we_o;
   logic             s_cyc_o;
   logic             s_stb_o;
   logic [DW-1:0]    s_dat_i;
   logic             s_ack_i;
   logic             s_err_i;
   logic             s_rty_i;
   logic [NM-1:0]    gnt_o;
   logic             tmo_o;
   logic [1:0]       tmo_mst_o;
   logic             tmo_clr_i;

   logic man_ack;
   logic auto_ack;
   int   checks;
   int   failures;

   // Slave model: acks every strobe when auto_ack is set, or on demand.
   assign s_ack_i = man_ack | (auto_ack & s_stb_o);

   sdram_wb_arb #(
      .NM (NM), .AW (AW), .DW (DW), .SW (SW), .TMO (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m_adr_i   (m_adr_i),
      .m_dat_i   (m_dat_i),
      .m_sel_i   (m_sel_i),
      .m_we_i    (m_we_i),
      .m_cyc_i   (m_cyc_i),
      .m_stb_i   (m_stb_i),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_rty_o   (m_rty_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_we_o    (s_we_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_rty_i   (s_rty_i),
      .gnt_o     (gnt_o),
      .tmo_o     (tmo_o),
      .tmo_mst_o (tmo_mst_o),
      .tmo_clr_i (tmo_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [2:0] rr_cyc [12];
   logic [2:0] rr_gnt [12];
   logic [2:0] rr_ack [12];
   logic [2:0] bu_cyc [8];
   logic [2:0] bu_gnt [8];
   logic [2:0] bu_ack [8];
   logic [AW-1:0] bu_adr [8];

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      m_adr_i   = {24'h300000, 24'h200000, 24'h100000};
      m_dat_i   = {32'h33333333, 32'h22222222, 32'h11111111};
      m_sel_i   = 12'hFFF;
      m_we_i    = '0;
      m_cyc_i   = '0;
      m_stb_i   = '0;
      s_dat_i   = '0;
      s_err_i   = 1'b0;
      s_rty_i   = 1'b0;
      man_ack   = 1'b0;
      auto_ack  = 1'b0;
      tmo_clr_i = 1'b0;

      rr_cyc = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011,
                 3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
      rr_gnt = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
      rr_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
      bu_cyc = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b100, 3'b100, 3'b000, 3'b000};
      bu_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b000};
      bu_ack = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000};
      bu_adr = '{24'h100000, 24'h100000, 24'h100000, 24'h100000,
                 24'h100000, 24'h300000, 24'h300000, 24'h000000};

      // Reset values
      tick();
      tick();
      #3;
      chk("rst_gnt", 64'(gnt_o), 0);
      chk("rst_scyc", 64'(s_cyc_o), 0);
      chk("rst_sstb", 64'(s_stb_o), 0);
      chk("rst_term", 64'({m_ack_o, m_err_o, m_rty_o}), 0);
      chk("rst_tmo", 64'({tmo_o, tmo_mst_o}), 0);

      // Single read by master 1, acked two cycles after grant
      tick();
      rst = 1'b0;
      m_cyc_i = 3'b010;
      m_stb_i = 3'b010;
      #3;
      chk("rd_gnt_lat", 64'(gnt_o), 0);
      tick();
      #3;
      chk("rd_gnt", 64'(gnt_o), 'h2);
      chk("rd_scyc", 64'(s_cyc_o), 1);
      chk("rd_sadr", 64'(s_adr_o), 'h200000);
      chk("rd_noack", 64'(m_ack_o), 0);
      tick();
      #3;
      chk("rd_noack2", 64'(m_ack_o), 0);
      tick();
      man_ack = 1'b1;
      s_dat_i = 32'hDEADBEEF;
      #3;
      chk("rd_ack", 64'(m_ack_o), 'h2);
      chk("rd_dat", 64'(m_dat_o), 'hDEADBEEF);
      tick();
      man_ack = 1'b0;
      m_cyc_i = '0;
      m_stb_i = '0;
      #3;
      chk("rd_hold", 64'(gnt_o), 'h2);
      tick();
      #3;
      chk("rd_idle_gnt", 64'(gnt_o), 0);
      chk("rd_idle_scyc", 64'(s_cyc_o), 0);

      // Round robin with three continuous requesters
      reset_dut();
      auto_ack = 1'b1;
      m_cyc_i = 3'b111;
      m_stb_i = 3'b111;
      #3;
      chk("rr_gnt_pre", 64'(gnt_o), 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         m_cyc_i = rr_cyc[i];
         m_stb_i = rr_cyc[i];
         #3;
         chk("rr_gnt", 64'(gnt_o), 64'(rr_gnt[i]));
         chk("rr_ack", 64'(m_ack_o), 64'(rr_ack[i]));
      end

      // Master 0 burst holds off master 2
      reset_dut();
      m_cyc_i = 3'b101;
      m_stb_i = 3'b101;
      #3;
      chk("bu_gnt_pre", 64'(gnt_o), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         m_cyc_i = bu_cyc[i];
         m_stb_i = bu_cyc[i];
         #3;
         chk("bu_gnt", 64'(gnt_o), 64'(bu_gnt[i]));
         chk("bu_adr", 64'(s_adr_o), 64'(bu_adr[i]));
         chk("bu_ack", 64'(m_ack_o), 64'(bu_ack[i]));
      end

      // Watchdog on master 2
      reset_dut();
      auto_ack = 1'b0;
      m_cyc_i = 3'b100;
      m_stb_i = 3'b100;
      for (int i = 1; i <= 8; i++) begin
         tick();
         #3;
         chk("wd_err_quiet", 64'(m_err_o), 0);
         chk("wd_scyc", 64'(s_cyc_o), 1);
      end
      tick();
      m_cyc_i = 3'b101;
      m_stb_i = 3'b101;
      #3;
      chk("wd_err", 64'(m_err_o), 'h4);
      chk("wd_scyc_fire", 64'(s_cyc_o), 0);
      chk("wd_sstb_fire", 64'(s_stb_o), 0);
      chk("wd_tmo_pre", 64'(tmo_o), 0);
      tick();
      #3;
      chk("wd_gnt_idle", 64'(gnt_o), 0);
      chk("wd_err_once", 64'(m_err_o), 0);
      chk("wd_tmo", 64'(tmo_o), 1);
      chk("wd_tmo_mst", 64'(tmo_mst_o), 2);
      tick();
      #3;
      chk("wd_regrant", 64'(gnt_o), 'h1);

      // Second timeout (master 0) coinciding with tmo_clr_i
      for (int i = 0; i < 7; i++) begin
         tick();
      end
      tick();
      tmo_clr_i = 1'b1;
      #3;
      chk("clr_err", 64'(m_err_o), 'h1);
      tick();
      tmo_clr_i = 1'b0;
      m_cyc_i = '0;
      m_stb_i = '0;
      #3;
      chk("clr_set_wins", 64'(tmo_o), 1);
      chk("clr_mst", 64'(tmo_mst_o), 0);
      chk("clr_gnt", 64'(gnt_o), 0);
      tick();
      tmo_clr_i = 1'b1;
      #3;
      chk("clr_pending", 64'(tmo_o), 1);
      tick();
      tmo_clr_i = 1'b0;
      #3;
      chk("clr_done", 64'(tmo_o), 0);

      // Reset mid-burst while master 1 is granted
      tick();
      m_cyc_i = 3'b010;
      m_stb_i = 3'b010;
      tick();
      #3;
      chk("mr_gnt", 64'(gnt_o), 'h2);
      tick();
      rst = 1'b1;
      auto_ack = 1'b1;
      tick();
      rst = 1'b0;
      m_cyc_i = 3'b011;
      m_stb_i = 3'b011;
      #3;
      chk("mr_gnt_drop", 64'(gnt_o), 0);
      chk("mr_scyc", 64'(s_cyc_o), 0);
      chk("mr_term", 64'({m_ack_o, m_err_o}), 0);
      tick();
      #3;
      chk("mr_first", 64'(gnt_o), 'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
